lcd12864_bus_arbiter: RTL and testbench

//  Shares one ST7920 (12864) parallel write bus between two requesters and sequences every

---
 rtl/lcd12864_pkg.sv | 29 ++
 rtl/lcd12864_bus_arbiter_delay_counter.sv | 29 ++
 rtl/lcd12864_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_lcd12864_bus_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd12864_pkg.sv
// Shared types, LCD command codes and default timing for the ST7920 write-bus arbiter.
package lcd12864_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        EXEC
    } state_t;

    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_HOME    = 8'h02;
    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h30;

    // Default timing in clk cycles at 50 MHz
    localparam int DEF_T_SETUP = 4;
    localparam int DEF_T_EN    = 16;
    localparam int DEF_T_HOLD  = 4;
    localparam int DEF_T_EXEC  = 3600;
    localparam int DEF_T_CLEAR = 80000;
    localparam int DEF_CNT_W   = 17;

    // CLEAR and HOME need the long execution wait; data bytes never do.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
        return !rs && ((dat == LCD_CMD_CLEAR) || (dat == LCD_CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd12864_bus_arbiter_delay_counter.sv
// Loadable down-counter shared by every timed phase of the LCD write cycle.
module lcd_delay_counter
    import lcd12864_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // Loading N-1 on phase entry makes the phase last exactly N cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd12864_bus_arbiter.sv
// Two-requester arbiter and byte sequencer driving the ST7920 parallel write pins.
module lcd12864_bus_arbiter
    import lcd12864_pkg::*;
#(
    parameter int T_SETUP = DEF_T_SETUP,
    parameter int T_EN    = DEF_T_EN,
    parameter int T_HOLD  = DEF_T_HOLD,
    parameter int T_EXEC  = DEF_T_EXEC,
    parameter int T_CLEAR = DEF_T_CLEAR,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_dat,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_dat,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dat,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_CLEAR = CNT_W'(T_CLEAR - 1);

    state_t           state;
    logic             acc0;
    logic             acc1;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

    // Ready is offered only in IDLE so an accept starts SETUP on the same edge,
    // giving the 1 + SETUP + EN + HOLD + wait accept-to-accept period.
    assign acc0       = !rst && (state == IDLE) && req0_valid;
    assign acc1       = !rst && (state == IDLE) && !req0_valid && req1_valid;
    assign req0_ready = acc0;
    assign req1_ready = acc1;
    assign lcd_rw     = 1'b0;

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (acc0 || acc1) begin
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = LD_EN;
                end
            end
            EN_HI: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = LD_HOLD;
                end
            end
            HOLD: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    cnt_val  = is_long_cmd(lcd_rs, lcd_dat) ? LD_CLEAR : LD_EXEC;
                end
            end
            default: ;
        endcase
    end

    lcd_delay_counter #(
        .CNT_W(CNT_W)
    ) u_delay (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(cnt_val),
        .done    (cnt_done)
    );

    // lcd_rs/lcd_dat double as the latched request and hold through EXEC and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lcd_rs  <= 1'b0;
            lcd_en  <= 1'b0;
            lcd_dat <= 8'h00;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0) begin
                        lcd_rs  <= req0_rs;
                        lcd_dat <= req0_dat;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end else if (acc1) begin
                        lcd_rs  <= req1_rs;
                        lcd_dat <= req1_dat;
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b1;
                        state  <= EN_HI;
                    end
                end
                EN_HI: begin
                    if (cnt_done) begin
                        lcd_en <= 1'b0;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    lcd_en <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd12864_bus_arbiter.sv
// Directed bench for lcd12864_bus_arbiter: reset abort, priority, timing and EXEC lengths.
module tb_lcd12864_bus_arbiter;

    localparam int T_SETUP = 4;
    localparam int T_EN    = 16;
    localparam int T_HOLD  = 4;
    localparam int T_EXEC  = 3600;
    // CLEAR wait shortened so the whole run stays well under 100k cycles
    localparam int T_CLEAR = 8000;
    localparam int XFER    = T_SETUP + T_EN + T_HOLD;

    logic       clk;
    logic       rst;
    logic       req0_valid, req0_rs, req0_ready;
    logic [7:0] req0_dat;
    logic       req1_valid, req1_rs, req1_ready;
    logic [7:0] req1_dat;
    logic       lcd_rs, lcd_rw, lcd_en, busy;
    logic [7:0] lcd_dat;

    int n_assert = 0;
    int n_fail   = 0;

    // Monitor state
    logic       prev_busy = 1'b0;
    logic       prev_en   = 1'b0;
    logic       rw_bad    = 1'b0;
    int         cyc       = 0;
    int         en_run    = 0;
    int         setup_len = 0;
    int         en_len    = 0;
    int         wr_count  = 0;
    logic [8:0] cap;
    logic [8:0] wlog [0:31];

    lcd12864_bus_arbiter #(
        .T_SETUP(T_SETUP),
        .T_EN   (T_EN),
        .T_HOLD (T_HOLD),
        .T_EXEC (T_EXEC),
        .T_CLEAR(T_CLEAR),
        .CNT_W  (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_rs   (req0_rs),
        .req0_dat  (req0_dat),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_rs   (req1_rs),
        .req1_dat  (req1_dat),
        .req1_ready(req1_ready),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat   (lcd_dat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: phase lengths, byte log, rs/dat stability, rw stuck low
    initial begin
        forever begin
            @(negedge clk);
            if (lcd_rw !== 1'b0) rw_bad = 1'b1;
            if (rst) begin
                prev_busy = 1'b0;
                prev_en   = 1'b0;
                cyc       = 0;
            end else begin
                if (busy && !prev_busy) begin
                    cyc = 0;
                    cap = {lcd_rs, lcd_dat};
                end else if (busy) begin
                    cyc++;
                    if (cyc < XFER) chk("rs_dat_stable", 32'({lcd_rs, lcd_dat}), 32'(cap));
                end
                if (lcd_en && !prev_en) begin
                    setup_len = cyc;
                    en_run    = 1;
                    if (wr_count < 32) wlog[wr_count] = {lcd_rs, lcd_dat};
                    wr_count++;
                end else if (lcd_en) begin
                    en_run++;
                end
                if (!lcd_en && prev_en) en_len = en_run;
                prev_busy = busy;
                prev_en   = lcd_en;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic do_req(input string tag, input int who, input logic rs,
                          input logic [7:0] dat, input int budget, output int waited);
        logic rdy;
        if (who == 0) begin
            req0_rs = rs; req0_dat = dat; req0_valid = 1'b1;
        end else begin
            req1_rs = rs; req1_dat = dat; req1_valid = 1'b1;
        end
        waited = 0;
        #1;
        rdy = (who == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < budget) begin
            @(negedge clk);
            #1;
            waited++;
            rdy = (who == 0) ? req0_ready : req1_ready;
        end
        chk({tag, "_accept"}, 32'(rdy), 32'd1);
        @(negedge clk);
        if (who == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
        #1;
        rdy = (who == 0) ? req0_ready : req1_ready;
        chk({tag, "_strobe_1cyc"}, 32'(rdy), 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int w;
        int wc;
        rst = 1'b1;
        req0_valid = 1'b0; req0_rs = 1'b0; req0_dat = 8'h00;
        req1_valid = 1'b0; req1_rs = 1'b0; req1_dat = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_lcd_rs",  32'(lcd_rs),     32'd0);
        chk("rst_lcd_rw",  32'(lcd_rw),     32'd0);
        chk("rst_lcd_en",  32'(lcd_en),     32'd0);
        chk("rst_lcd_dat", 32'(lcd_dat),    32'h00);
        chk("rst_ready0",  32'(req0_ready), 32'd0);
        chk("rst_ready1",  32'(req1_ready), 32'd0);
        chk("rst_busy",    32'(busy),       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Test 1: reset in the middle of EN_HI
        do_req("t1", 0, 1'b0, 8'h30, 4, w);
        chk("t1_busy", 32'(busy), 32'd1);
        w = 0;
        while (!lcd_en && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("t1_en_hi", 32'(lcd_en), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t1_abort_en",   32'(lcd_en),  32'd0);
        chk("t1_abort_busy", 32'(busy),    32'd0);
        chk("t1_abort_rs",   32'(lcd_rs),  32'd0);
        chk("t1_abort_dat",  32'(lcd_dat), 32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Test 2: req1 alone, timing and back-to-back period
        do_req("t2a", 1, 1'b1, 8'h41, 4, w);
        chk("t2_first_wait", 32'(w), 32'd0);
        do_req("t2b", 1, 1'b1, 8'h42, T_EXEC + 100, w);
        chk("t2_period",    32'(w),           32'(XFER + T_EXEC));
        chk("t2_setup_len", 32'(setup_len),   32'(T_SETUP));
        chk("t2_en_len",    32'(en_len),      32'(T_EN));
        chk("t2_byte",      32'(wlog[wr_count - 1]), 32'h141);
        wait_idle("t2_idle", T_EXEC + 100);

        // Test 3: simultaneous requests, req0 wins, req1 follows
        req1_rs = 1'b1; req1_dat = 8'h4D; req1_valid = 1'b1;
        req0_rs = 1'b0; req0_dat = 8'h30; req0_valid = 1'b1;
        #1;
        chk("t3_req0_wins",    32'(req0_ready), 32'd1);
        chk("t3_req1_blocked", 32'(req1_ready), 32'd0);
        do_req("t3a", 0, 1'b0, 8'h30, 0, w);
        chk("t3_req1_held", 32'(req1_valid), 32'd1);
        do_req("t3b", 1, 1'b1, 8'h4D, T_EXEC + 100, w);
        chk("t3_req1_wait", 32'(w), 32'(XFER + T_EXEC));
        wait_idle("t3_idle", T_EXEC + 100);
        chk("t3_bus_first",  32'(wlog[wr_count - 2]), 32'h030);
        chk("t3_bus_second", 32'(wlog[wr_count - 1]), 32'h14D);

        // Test 4: EXEC length depends on rs and command code
        do_req("t4a", 0, 1'b0, 8'h01, 4, w);
        do_req("t4b", 0, 1'b0, 8'h0C, T_CLEAR + 100, w);
        chk("t4_clear_wait", 32'(w), 32'(XFER + T_CLEAR));
        do_req("t4c", 0, 1'b1, 8'h01, T_CLEAR + 100, w);
        chk("t4_cmd0c_wait", 32'(w), 32'(XFER + T_EXEC));
        do_req("t4d", 0, 1'b0, 8'h30, T_CLEAR + 100, w);
        chk("t4_data01_wait", 32'(w), 32'(XFER + T_EXEC));
        wait_idle("t4_idle", T_EXEC + 100);

        // Test 5: one-cycle req1 pulse while busy is ignored
        do_req("t5", 0, 1'b0, 8'h0C, 4, w);
        repeat (30) @(negedge clk);
        wc = wr_count;
        req1_rs = 1'b1; req1_dat = 8'h55; req1_valid = 1'b1;
        #1;
        chk("t5_no_ready", 32'(req1_ready), 32'd0);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_idle("t5_idle", T_EXEC + 100);
        repeat (40) @(negedge clk);
        chk("t5_no_write",   32'(wr_count), 32'(wc));
        chk("t5_dat_kept",   32'(lcd_dat),  32'h0C);
        chk("t5_rs_kept",    32'(lcd_rs),   32'd0);

        // Test 6: write-only bus
        chk("t6_rw_low", 32'(rw_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
